avr_cpu_progmem_prog: RTL and testbench
=======================================

Name: avr_cpu_progmem_prog

Overview:
- Parametrised program memory for the AVR core: synchronous instruction-fetch read port plus a byte-stream programming port (bootloader/loader path).
- Programming assembles little-endian bytes into instruction words and writes them at an auto-incrementing address.
- CPU fetches are stalled while programming is active.
- Sits between the core fetch stage and the external loader (UART/SPI bridge).

Parameters:
- ADDR_WIDTH, 9, word address width.
- DATA_WIDTH, 16, instruction word width; must be a multiple of 8.
- MEM_SIZE, 512, number of words; must be <= 2**ADDR_WIDTH.
- BYTES, DATA_WIDTH/8, derived localparam: bytes per word.
- PAD_BYTE, 8'hFF, fill value for an incomplete final word (erased-flash value).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  fetch word address.
- fetch_data  out  DATA_WIDTH  registered instruction word.
- fetch_valid  out  1  fetch_data holds the result of the previous cycle's request.
- cpu_stall  out  1  high whenever the programming FSM is not IDLE.
- prog_start  in  1  pulse: begin session at prog_addr.
- prog_addr  in  ADDR_WIDTH  session start word address.
- prog_stop  in  1  pulse: end session; flush any partial word.
- prog_byte_valid  in  1  byte handshake valid.
- prog_byte  in  8  data byte, LSB-first within a word.
- prog_byte_ready  out  1  byte handshake ready.
- prog_done  out  1  one-cycle pulse when the session completes.
- prog_overflow  out  1  sticky flag: write pointer wrapped past MEM_SIZE-1.
- prog_word_count  out  ADDR_WIDTH+1  words written in the current or last session.

Behaviour:
- Reset values:
  - fetch_data=0, fetch_valid=0, cpu_stall=0.
  - prog_byte_ready=0, prog_done=0, prog_overflow=0, prog_word_count=0.
  - FSM=IDLE, byte index=0, write pointer=0, assembly register=0.
  - Memory contents are not cleared; simulation preloads from hex.
- Fetch:
  - One-cycle latency: fetch_data <= mem[fetch_addr] and fetch_valid <= fetch_en & ~cpu_stall.
  - When no fetch is accepted, fetch_data holds its value.
  - fetch_addr >= MEM_SIZE returns 0.
- Byte handshake: a byte transfers when prog_byte_valid & prog_byte_ready.
  - prog_byte_ready is high only in RECV.
- FSM states:
  - IDLE:
    - prog_start -> RECV.
    - On entry to RECV: pointer<=prog_addr, index<=0, count<=0, overflow<=0.
  - RECV:
    - An accepted byte goes to lane [index*8 +: 8]; index increments.
    - When the byte with index==BYTES-1 is accepted -> WRITE.
    - prog_stop with no byte transfer: index==0 -> DONE; index>0 -> FLUSH.
    - prog_stop in the same cycle as a transfer: the byte is accepted first.
      - If that byte completes the word -> WRITE; the stop is latched and consumed after WRITE.
      - Otherwise -> FLUSH.
  - WRITE, 1 cycle:
    - mem[pointer] <= assembled word.
    - count++.
    - Pointer advances; at MEM_SIZE-1 it wraps to 0 and sets overflow.
    - index <= 0.
    - Next state: latched stop -> DONE, else RECV.
  - FLUSH, 1 cycle:
    - Unfilled lanes take PAD_BYTE.
    - Write, count, pointer and overflow update exactly as in WRITE.
    - Next state -> DONE.
  - DONE, 1 cycle: prog_done=1 -> IDLE.
- prog_start in any non-IDLE state:
  - Restart: partial word discarded, no write.
  - pointer, index and count reload; go to RECV.
  - prog_start takes priority over prog_stop and any byte transfer that cycle.
- cpu_stall = (state != IDLE); it drops in the same cycle DONE exits.
- prog_overflow and prog_word_count persist after DONE until the next prog_start or rst.
- rst mid-session: FSM returns to IDLE immediately.
  - Partial word is discarded.
  - Words already written remain in memory.

Decomposition:
- Shared package avr_progmem_pkg:
  - FSM state enum (IDLE, RECV, WRITE, FLUSH, DONE).
  - PAD_BYTE default.
  - Helper function for the derived BYTES.
- Sub-module avr_progmem_ram: simple dual-port RAM, 1 write port + 1 synchronous read port, MEM_SIZE x DATA_WIDTH.
  - Holds the simulation preload and maps to block RAM.
- Top level holds the fetch logic and the programming FSM.

Test Plan:
- Fetch after reset, memory preloaded mem[5]=16'h940C: fetch_en=1, fetch_addr=5 -> next cycle fetch_data=16'h940C, fetch_valid=1; before that fetch_valid=0.
- Program session:
  - Stimulus: prog_start with prog_addr=3; bytes 0x0C,0x94,0x34,0x12; prog_stop.
  - Required: mem[3]=16'h940C, mem[4]=16'h1234, prog_word_count=2, one prog_done pulse.
  - Required: cpu_stall high throughout; fetch_valid=0 for fetches issued during the session.
- Odd byte flush: prog_start at 0; bytes 0xAA,0xBB,0xCC; prog_stop -> mem[0]=16'hBBAA, mem[1]=16'hFFCC, count=2.
- Wrap: prog_start at 511; 4 bytes -> writes to words 511 and 0, prog_overflow=1, and it stays set after DONE.
- Simultaneous events:
  - prog_stop in the same cycle as the 2nd byte -> word written, then DONE, no pad write.
  - prog_start mid-word -> partial word discarded, count=0, new pointer loaded.
- rst after 1 byte of a word -> state IDLE, cpu_stall=0, prog_byte_ready=0, target word unchanged; the next fetch is served normally.

Source files
------------

// File: rtl/avr_progmem_pkg.sv
// Shared types and helpers for the AVR program memory with byte-stream loader.
package avr_progmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    FLUSH,
    DONE
  } prog_state_e;

  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hFF;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int index_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/avr_progmem_ram.sv
// Simple dual-port instruction RAM: one write port, one registered read port.
module avr_progmem_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (i_wr_en && (int'(i_wr_addr) < MEM_SIZE)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= (int'(i_rd_addr) < MEM_SIZE) ? r_mem[i_rd_addr] : '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/avr_cpu_progmem_prog.sv
// AVR program memory: registered fetch port plus a byte-stream loader that
// assembles little-endian words and writes them at an auto-incrementing pointer.
module avr_cpu_progmem_prog
  import avr_progmem_pkg::*;
#(
  parameter int         ADDR_WIDTH = 9,
  parameter int         DATA_WIDTH = 16,
  parameter int         MEM_SIZE   = 512,
  parameter logic [7:0] PAD_BYTE   = PAD_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  output logic                  cpu_stall,
  input  logic                  prog_start,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic                  prog_stop,
  input  logic                  prog_byte_valid,
  input  logic [7:0]            prog_byte,
  output logic                  prog_byte_ready,
  output logic                  prog_done,
  output logic                  prog_overflow,
  output logic [ADDR_WIDTH:0]   prog_word_count
);

  localparam int                    BYTES     = bytes_per_word(DATA_WIDTH);
  localparam int                    IDX_W     = index_width(BYTES);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  prog_state_e           r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [DATA_WIDTH-1:0] r_asm;
  logic                  r_stop_pend;
  logic                  r_overflow;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_fetch_valid;

  logic                  w_xfer;
  logic                  w_commit;
  logic                  w_fetch_accept;
  logic [DATA_WIDTH-1:0] w_pad_word;
  logic [DATA_WIDTH-1:0] w_wr_data;

  assign cpu_stall       = (r_state != IDLE);
  assign prog_byte_ready = (r_state == RECV);
  assign prog_done       = (r_state == DONE);
  assign prog_overflow   = r_overflow;
  assign prog_word_count = r_count;
  assign fetch_valid     = r_fetch_valid;

  assign w_xfer         = prog_byte_valid & prog_byte_ready;
  assign w_fetch_accept = fetch_en & ~cpu_stall;
  // A restart wins over a pending write, so the word in flight is dropped.
  assign w_commit       = ((r_state == WRITE) || (r_state == FLUSH)) && !prog_start;

  // NOTE: start from a full default so no path leaves w_pad_word unassigned (no latch).
  always_comb begin
    w_pad_word = r_asm;
    for (int b = 0; b < BYTES; b++) begin
      if (b >= int'(r_idx)) begin
        w_pad_word[b*8 +: 8] = PAD_BYTE;
      end
    end
  end

  assign w_wr_data = (r_state == FLUSH) ? w_pad_word : r_asm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_valid <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_ptr       <= '0;
      r_asm       <= '0;
      r_stop_pend <= 1'b0;
      r_overflow  <= 1'b0;
      r_count     <= '0;
    end else if (prog_start) begin
      r_state     <= RECV;
      r_idx       <= '0;
      r_ptr       <= prog_addr;
      r_asm       <= '0;
      r_stop_pend <= 1'b0;
      r_overflow  <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= IDLE;
        RECV: begin
          if (w_xfer) begin
            r_asm[r_idx*8 +: 8] <= prog_byte;
            if (r_idx == LAST_IDX) begin
              r_state     <= WRITE;
              r_stop_pend <= prog_stop;
            end else begin
              r_idx <= r_idx + 1'b1;
              if (prog_stop) r_state <= FLUSH;
            end
          end else if (prog_stop) begin
            r_state <= (r_idx == '0) ? DONE : FLUSH;
          end
        end
        WRITE, FLUSH: begin
          r_count <= r_count + 1'b1;
          if (r_ptr == LAST_ADDR) begin
            r_ptr      <= '0;
            r_overflow <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
          r_idx       <= '0;
          r_asm       <= '0;
          r_stop_pend <= 1'b0;
          r_state     <= ((r_state == FLUSH) || r_stop_pend) ? DONE : RECV;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  avr_progmem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_commit),
    .i_wr_addr(r_ptr),
    .i_wr_data(w_wr_data),
    .i_rd_en  (w_fetch_accept),
    .i_rd_addr(fetch_addr),
    .o_rd_data(fetch_data)
  );

endmodule

// File: tb/tb_avr_cpu_progmem_prog.sv
// Scoreboard bench: the driver pushes expected fetch words and session results,
// a negedge monitor pops them whenever fetch_valid or prog_done is presented.
module tb_avr_cpu_progmem_prog;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MS = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          cpu_stall;
  logic          prog_start;
  logic [AW-1:0] prog_addr;
  logic          prog_stop;
  logic          prog_byte_valid;
  logic [7:0]    prog_byte;
  logic          prog_byte_ready;
  logic          prog_done;
  logic          prog_overflow;
  logic [AW:0]   prog_word_count;

  always #5 clk = ~clk;

  avr_cpu_progmem_prog #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE  (MS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .fetch_addr     (fetch_addr),
    .fetch_data     (fetch_data),
    .fetch_valid    (fetch_valid),
    .cpu_stall      (cpu_stall),
    .prog_start     (prog_start),
    .prog_addr      (prog_addr),
    .prog_stop      (prog_stop),
    .prog_byte_valid(prog_byte_valid),
    .prog_byte      (prog_byte),
    .prog_byte_ready(prog_byte_ready),
    .prog_done      (prog_done),
    .prog_overflow  (prog_overflow),
    .prog_word_count(prog_word_count)
  );

  typedef struct {
    int count;
    bit ovf;
  } done_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] ref_mem [MS];
  bit          known   [MS];
  logic [15:0] fetch_q [$];
  done_t       done_q  [$];

  // Reference session model: pending bytes, pointer, count and overflow.
  int          m_ptr;
  int          m_count;
  bit          m_ovf;
  logic [7:0]  m_pend [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_commit(input logic [15:0] w);
    ref_mem[m_ptr] = w;
    known[m_ptr]   = 1'b1;
    m_count++;
    m_ptr = (m_ptr + 1) % MS;
    if (m_ptr == 0) m_ovf = 1'b1;
  endtask

  task automatic m_byte(input logic [7:0] b);
    m_pend.push_back(b);
    if (m_pend.size() == 2) begin
      m_commit({m_pend[1], m_pend[0]});
      m_pend.delete();
    end
  endtask

  task automatic m_stop();
    done_t d;
    if (m_pend.size() > 0) m_commit({8'hFF, m_pend[0]});
    m_pend.delete();
    d.count = m_count;
    d.ovf   = m_ovf;
    done_q.push_back(d);
  endtask

  task automatic start_session(input int addr);
    prog_start = 1'b1;
    prog_addr  = AW'(addr);
    tick();
    prog_start = 1'b0;
    m_ptr   = addr;
    m_count = 0;
    m_ovf   = 1'b0;
    m_pend.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_stop, input bit try_fetch);
    int budget = 0;
    bit sent   = 1'b0;
    prog_byte_valid = 1'b1;
    prog_byte       = b;
    prog_stop       = with_stop;
    if (try_fetch) begin
      fetch_en   = 1'b1;
      fetch_addr = AW'($urandom_range(0, MS - 1));
    end
    while (!sent && budget < 20) begin
      check("stall_in_session", cpu_stall, 1);
      if (prog_byte_ready) sent = 1'b1;
      tick();
      budget++;
    end
    prog_byte_valid = 1'b0;
    prog_stop       = 1'b0;
    fetch_en        = 1'b0;
    if (!sent) check("byte_handshake_timeout", 0, 1);
    m_byte(b);
    if (with_stop) m_stop();
  endtask

  task automatic stop_session();
    int budget = 0;
    while (!prog_byte_ready && budget < 20) begin
      tick();
      budget++;
    end
    if (!prog_byte_ready) check("stop_ready_timeout", 0, 1);
    prog_stop = 1'b1;
    tick();
    prog_stop = 1'b0;
    m_stop();
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (cpu_stall && budget < 50) begin
      tick();
      budget++;
    end
    if (cpu_stall) check("idle_timeout", 0, 1);
    check("overflow_after_done", prog_overflow, m_ovf);
    check("count_after_done", prog_word_count, m_count);
  endtask

  task automatic do_fetch(input int addr);
    fetch_en   = 1'b1;
    fetch_addr = AW'(addr);
    fetch_q.push_back(ref_mem[addr]);
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic fetch_known();
    for (int a = 0; a < MS; a++) begin
      if (known[a]) do_fetch(a);
    end
  endtask

  logic [15:0] mon_exp;
  done_t       mon_d;

  always @(negedge clk) begin
    if (!rst) begin
      if (fetch_valid) begin
        if (fetch_q.size() == 0) begin
          check("unexpected_fetch_valid", 1, 0);
        end else begin
          mon_exp = fetch_q.pop_front();
          check("fetch_data", fetch_data, mon_exp);
        end
      end
      if (prog_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_prog_done", 1, 0);
        end else begin
          mon_d = done_q.pop_front();
          check("done_word_count", prog_word_count, mon_d.count);
          check("done_overflow", prog_overflow, mon_d.ovf);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    fetch_addr = '0;
    prog_start = 1'b0;
    prog_addr = '0;
    prog_stop = 1'b0;
    prog_byte_valid = 1'b0;
    prog_byte = '0;
    for (int a = 0; a < MS; a++) known[a] = 1'b0;
    tick();
    tick();
    check("rst_fetch_data", fetch_data, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_byte_ready", prog_byte_ready, 0);
    check("rst_prog_done", prog_done, 0);
    check("rst_overflow", prog_overflow, 0);
    check("rst_word_count", prog_word_count, 0);
    rst = 1'b0;
    tick();

    // Preload word 5, reset, then fetch it back.
    start_session(5);
    send_byte(8'h0C, 1'b0, 1'b0);
    send_byte(8'h94, 1'b0, 1'b0);
    stop_session();
    wait_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_count = 0;
    m_ovf   = 1'b0;
    check("fetch_valid_before_fetch", fetch_valid, 0);
    check("count_cleared_by_rst", prog_word_count, 0);
    do_fetch(5);

    // Two-word session with fetches attempted while stalled.
    start_session(3);
    send_byte(8'h0C, 1'b0, 1'b1);
    send_byte(8'h94, 1'b0, 1'b1);
    send_byte(8'h34, 1'b0, 1'b1);
    send_byte(8'h12, 1'b0, 1'b1);
    stop_session();
    wait_idle();
    do_fetch(3);
    do_fetch(4);

    // Odd byte count flushes with pad.
    start_session(0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b0);
    stop_session();
    wait_idle();
    do_fetch(0);
    do_fetch(1);

    // Pointer wrap sets the sticky overflow flag.
    start_session(511);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    stop_session();
    wait_idle();
    tick();
    check("overflow_sticky_later", prog_overflow, 1);
    do_fetch(511);
    do_fetch(0);

    // Stop together with the completing byte: no pad write into 101.
    start_session(100);
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i), 1'b0, 1'b0);
    stop_session();
    wait_idle();
    start_session(100);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    wait_idle();
    do_fetch(100);
    do_fetch(101);

    // Restart mid-word discards the partial word.
    start_session(200);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    stop_session();
    wait_idle();
    start_session(200);
    send_byte(8'h55, 1'b0, 1'b0);
    start_session(210);
    check("restart_count_zero", prog_word_count, 0);
    check("restart_stall", cpu_stall, 1);
    send_byte(8'h66, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0);
    stop_session();
    wait_idle();
    do_fetch(200);
    do_fetch(210);

    // Reset after one byte of a word.
    start_session(40);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    stop_session();
    wait_idle();
    start_session(40);
    send_byte(8'h99, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pend.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    check("rst_mid_stall", cpu_stall, 0);
    check("rst_mid_ready", prog_byte_ready, 0);
    check("rst_mid_overflow", prog_overflow, 0);
    do_fetch(40);

    // Randomized sessions, then read back every word written so far.
    for (int s = 0; s < 10; s++) begin
      int  addr;
      int  nb;
      bit  joint;
      addr  = ($urandom_range(0, 3) == 0) ? $urandom_range(509, 511) : $urandom_range(0, MS - 1);
      nb    = $urandom_range(0, 7);
      joint = (nb > 0) && ($urandom_range(0, 1) == 1);
      start_session(addr);
      for (int i = 0; i < nb; i++) begin
        send_byte(8'($urandom), joint && (i == nb - 1), 1'($urandom_range(0, 1)));
      end
      if (!joint) stop_session();
      wait_idle();
    end
    fetch_known();

    for (int i = 0; i < 4; i++) tick();
    check("fetch_queue_drained", fetch_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
